fused_ofm_store: RTL and testbench

Write-back engine for the fused-layer datapath: accepts layer-2 result words from the fused compute pipeline, buffers them in a small FIFO and writes them into global BRAM as consecutive 32-bit words starting at a programmed base address. It is the global-BRAM writer paired with the fused load controller, which only reads global BRAM. It shares the global BRAM write port with other masters through a single-cycle grant.

---
 rtl/fused_pkg.sv | 13 +
 rtl/fused_wb_fifo.sv | 56 +++++
 rtl/fused_ofm_store.sv | 116 +++++++++++
 tb/tb_fused_ofm_store.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fused_pkg.sv
// Definitions shared by the fused-layer global-BRAM engines: the store FSM
// state type and the byte stride between consecutive 32-bit words.
package fused_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STORE = 2'd1,
      ST_DONE  = 2'd2
   } store_state_t;

   localparam int unsigned ADDR_STEP = 4;

endpackage

// File: rtl/fused_wb_fifo.sv
// Small synchronous write-back FIFO; push when full and pop when empty are
// dropped, and clr empties it in one cycle.
module fused_wb_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, whatever the block order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and count
   // define which entries are valid, and a reset here would block RAM mapping.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/fused_ofm_store.sv
// Fused-layer output write-back: buffers layer-2 result words and writes them
// to global BRAM as consecutive 32-bit words from a programmed base address.
module fused_ofm_store
   import fused_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr_OFM,
   input  logic [ADDR_W-1:0] size_OFM,
   input  logic              valid_layer2,
   input  logic [DATA_W-1:0] data_layer2,
   output logic              ready_layer2,
   input  logic              global_wr_gnt,
   output logic              global_wr_req,
   output logic              we_global,
   output logic [ADDR_W-1:0] wr_addr_global,
   output logic [DATA_W-1:0] wr_data_global,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = ADDR_W - 2;

   store_state_t      state_q, state_d;
   logic [CNT_W-1:0]  size_words;
   logic [CNT_W-1:0]  total_q, acc_q, wr_q, wr_d;
   logic [ADDR_W-1:0] next_addr_q, wr_addr_q;
   logic [DATA_W-1:0] wr_data_q, fifo_head;
   logic              we_q;
   logic              fifo_full, fifo_empty, fifo_clr;
   logic              push, pop;
   logic              unused_size_lsbs;

   // Sizes are whole words, so the two byte-offset bits carry no information.
   assign size_words       = size_OFM[ADDR_W-1:2];
   assign unused_size_lsbs = ^size_OFM[1:0];

   assign ready_layer2  = (state_q == ST_STORE) && !fifo_full && (acc_q < total_q);
   assign global_wr_req = (state_q == ST_STORE) && !fifo_empty;
   assign push          = valid_layer2 && ready_layer2;
   assign pop           = global_wr_req && global_wr_gnt;
   assign fifo_clr      = (state_q == ST_IDLE) && start;
   assign wr_d          = wr_q + CNT_W'(pop);

   fused_wb_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (fifo_clr),
      .push    (push),
      .pop     (pop),
      .wdata   (data_layer2),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

   // Leaving STORE on the edge that pops the last word lines DONE up with the
   // final registered write pulse.
   // NOTE: combinational logic uses blocking assignments and assigns a default
   // first, so no path through the case can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = (size_words == '0) ? ST_DONE : ST_STORE;
         ST_STORE: if (wr_d == total_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         total_q     <= '0;
         acc_q       <= '0;
         wr_q        <= '0;
         next_addr_q <= '0;
         we_q        <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q <= state_d;
         if (fifo_clr) begin
            total_q     <= size_words;
            acc_q       <= '0;
            wr_q        <= '0;
            next_addr_q <= base_addr_OFM;
         end else begin
            if (push) acc_q <= acc_q + CNT_W'(1);
            wr_q <= wr_d;
            // Running address equals base + 4*wr_cnt, wrapping modulo 2^ADDR_W.
            if (pop) next_addr_q <= next_addr_q + ADDR_W'(ADDR_STEP);
         end
         we_q <= pop;
         if (pop) begin
            wr_addr_q <= next_addr_q;
            wr_data_q <= fifo_head;
         end
      end
   end

   assign we_global      = we_q;
   assign wr_addr_global = wr_addr_q;
   assign wr_data_global = wr_data_q;
   assign busy           = (state_q == ST_STORE);
   assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_fused_ofm_store.sv
// Self-checking bench for fused_ofm_store: randomized producer data and grant
// patterns compared against the expected word list base + 4*i -> word i.
module tb_fused_ofm_store;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] base_addr_OFM, size_OFM;
   logic        valid_layer2;
   logic [31:0] data_layer2;
   logic        ready_layer2;
   logic        global_wr_gnt, global_wr_req;
   logic        we_global;
   logic [31:0] wr_addr_global, wr_data_global;
   logic        busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   // Results of the most recent job.
   logic [31:0] words[$];
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   int          n_acc, done_cnt, done_cyc, we_viol, ready_extra, acc_at_mark;
   logic        ready_first, busy_first, ready_at_mark, done_with_we;
   bit          timed_out, aborted;
   logic [6:0]  snap;

   fused_ofm_store #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .base_addr_OFM  (base_addr_OFM),
      .size_OFM       (size_OFM),
      .valid_layer2   (valid_layer2),
      .data_layer2    (data_layer2),
      .ready_layer2   (ready_layer2),
      .global_wr_gnt  (global_wr_gnt),
      .global_wr_req  (global_wr_req),
      .we_global      (we_global),
      .wr_addr_global (wr_addr_global),
      .wr_data_global (wr_data_global),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   // gmode: 0 always, 1 toggling, 2 low for glow cycles, 3 random.
   // vmode: 0 always, 1 random; valid only offered for cyc < vlimit.
   task automatic run_job(input logic [31:0] base, input logic [31:0] size,
                          input int gmode, input int glow, input int vmode,
                          input int vlimit, input int abort_at, input int max_cyc);
      int   cyc, post, total;
      logic prev_pop;
      total = int'(size >> 2);
      words.delete(); obs_addr.delete(); obs_data.delete();
      for (int i = 0; i <= total; i++) words.push_back($urandom);
      n_acc = 0; done_cnt = 0; done_cyc = -1; we_viol = 0; ready_extra = 0;
      acc_at_mark = -1; ready_at_mark = 1'bx; done_with_we = 1'b0;
      ready_first = 1'bx; busy_first = 1'bx; aborted = 0; snap = '1;
      @(negedge clk);
      start = 1'b1; base_addr_OFM = base; size_OFM = size;
      valid_layer2 = 1'b0; global_wr_gnt = 1'b0;
      @(negedge clk);
      start = 1'b0;
      prev_pop = 1'b0; post = -1; cyc = 0;
      while (cyc < max_cyc && post != 0) begin
         if (cyc == 0) begin ready_first = ready_layer2; busy_first = busy; end
         if (we_global) begin
            obs_addr.push_back(wr_addr_global);
            obs_data.push_back(wr_data_global);
         end
         if (we_global !== prev_pop) we_viol++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_with_we = we_global && (obs_addr.size() == total);
         end
         if (ready_layer2 && n_acc >= total) ready_extra++;
         if (cyc == glow) begin acc_at_mark = n_acc; ready_at_mark = ready_layer2; end
         if (abort_at >= 0 && obs_addr.size() == abort_at) begin
            reset_n = 1'b0; valid_layer2 = 1'b0; global_wr_gnt = 1'b0;
            #1;
            snap = {we_global, |wr_addr_global, |wr_data_global, busy, done,
                    ready_layer2, global_wr_req};
            #1;
            reset_n = 1'b1;
            aborted = 1;
            break;
         end
         case (gmode)
            0:       global_wr_gnt = 1'b1;
            1:       global_wr_gnt = (cyc % 2 == 0);
            2:       global_wr_gnt = (cyc >= glow);
            default: global_wr_gnt = ($urandom_range(0, 9) < 6);
         endcase
         valid_layer2 = (cyc < vlimit) && (vmode == 0 || $urandom_range(0, 9) < 7);
         data_layer2  = (n_acc < words.size()) ? words[n_acc] : 32'h0;
         if (valid_layer2 && ready_layer2) n_acc++;
         prev_pop = global_wr_gnt && global_wr_req;
         if (done && post < 0) post = 3;
         else if (post > 0) post--;
         cyc++;
         @(negedge clk);
      end
      timed_out = (post != 0) && !aborted;
      valid_layer2 = 1'b0; global_wr_gnt = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; base_addr_OFM = '0; size_OFM = '0;
      valid_layer2 = 1'b1; data_layer2 = 32'hdead_beef; global_wr_gnt = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({we_global, wr_addr_global, wr_data_global, busy, done, ready_layer2, global_wr_req} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: we=%b addr=%h data=%h busy=%b done=%b ready=%b req=%b, all required 0",
                  we_global, wr_addr_global, wr_data_global, busy, done, ready_layer2, global_wr_req);
      end
      valid_layer2 = 1'b0; global_wr_gnt = 1'b0;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({we_global, busy, done, ready_layer2} !== 4'b0) begin
         n_bad++;
         $display("FAIL idle_after_reset: we/busy/done/ready=%b required 0000", {we_global, busy, done, ready_layer2});
      end
   endtask

   task automatic test_basic();
      run_job(32'h1000, 32'd16, 0, 0, 0, 1000, -1, 200);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL basic_timeout: done never seen"); end
      n_cmp++; if (ready_first !== 1'b1 || busy_first !== 1'b1) begin
         n_bad++; $display("FAIL basic_first_cycle: ready=%b busy=%b required 1 1", ready_first, busy_first); end
      n_cmp++; if (obs_addr.size() !== 4) begin
         n_bad++; $display("FAIL basic_count: got %0d writes expected 4", obs_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
         n_cmp++;
         if (obs_addr[i] !== 32'h1000 + 32'(i) * 4 || obs_data[i] !== words[i]) begin
            n_bad++;
            $display("FAIL basic_write%0d: got %h/%h expected %h/%h", i, obs_addr[i], obs_data[i],
                     32'h1000 + 32'(i) * 4, words[i]);
         end
      end
      n_cmp++; if (done_cnt !== 1 || done_with_we !== 1'b1) begin
         n_bad++; $display("FAIL basic_done: pulses=%0d with_last_we=%b expected 1 1", done_cnt, done_with_we); end
      n_cmp++; if (we_viol !== 0) begin
         n_bad++; $display("FAIL basic_we_timing: %0d cycles off, expected 0", we_viol); end
      n_cmp++; if ({busy, done, we_global} !== 3'b0) begin
         n_bad++; $display("FAIL basic_back_idle: busy/done/we=%b expected 000", {busy, done, we_global}); end
   endtask

   task automatic test_backpressure();
      run_job(32'h2000, 32'd32, 2, 10, 0, 1000, -1, 300);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_timeout: done never seen"); end
      n_cmp++; if (acc_at_mark !== 4 || ready_at_mark !== 1'b0) begin
         n_bad++; $display("FAIL bp_stall: accepted=%0d ready=%b expected 4 0", acc_at_mark, ready_at_mark); end
      n_cmp++; if (obs_addr.size() !== 8) begin
         n_bad++; $display("FAIL bp_count: got %0d writes expected 8", obs_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < 8; i++) begin
         n_cmp++;
         if (obs_addr[i] !== 32'h2000 + 32'(i) * 4 || obs_data[i] !== words[i]) begin
            n_bad++;
            $display("FAIL bp_write%0d: got %h/%h expected %h/%h", i, obs_addr[i], obs_data[i],
                     32'h2000 + 32'(i) * 4, words[i]);
         end
      end
      n_cmp++; if (done_cnt !== 1 || done_with_we !== 1'b1 || we_viol !== 0) begin
         n_bad++; $display("FAIL bp_done: pulses=%0d with_last_we=%b we_off=%0d expected 1 1 0",
                           done_cnt, done_with_we, we_viol); end
   endtask

   task automatic test_grant_toggle();
      run_job(32'h3000, 32'd24, 1, 0, 0, 1000, -1, 300);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL tog_timeout: done never seen"); end
      n_cmp++; if (obs_addr.size() !== 6) begin
         n_bad++; $display("FAIL tog_count: got %0d writes expected 6", obs_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < 6; i++) begin
         n_cmp++;
         if (obs_addr[i] !== 32'h3000 + 32'(i) * 4 || obs_data[i] !== words[i]) begin
            n_bad++;
            $display("FAIL tog_write%0d: got %h/%h expected %h/%h", i, obs_addr[i], obs_data[i],
                     32'h3000 + 32'(i) * 4, words[i]);
         end
      end
      n_cmp++; if (we_viol !== 0 || done_with_we !== 1'b1) begin
         n_bad++; $display("FAIL tog_we_timing: we_off=%0d with_last_we=%b expected 0 1", we_viol, done_with_we); end
   endtask

   task automatic test_size_zero();
      run_job(32'h4000, 32'd0, 0, 0, 0, 1000, -1, 50);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL zero_timeout: done never seen"); end
      n_cmp++; if (obs_addr.size() !== 0) begin
         n_bad++; $display("FAIL zero_writes: got %0d writes expected 0", obs_addr.size()); end
      n_cmp++; if (done_cnt !== 1 || done_cyc !== 0) begin
         n_bad++; $display("FAIL zero_done: pulses=%0d at cycle %0d expected 1 at 0", done_cnt, done_cyc); end
      n_cmp++; if (ready_extra !== 0) begin
         n_bad++; $display("FAIL zero_ready: ready high %0d cycles expected 0", ready_extra); end
   endtask

   task automatic test_overrun();
      run_job(32'h5000, 32'd8, 0, 0, 0, 5, -1, 100);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL ovr_timeout: done never seen"); end
      n_cmp++; if (n_acc !== 2 || ready_extra !== 0) begin
         n_bad++; $display("FAIL ovr_accepts: accepted=%0d extra_ready=%0d expected 2 0", n_acc, ready_extra); end
      n_cmp++; if (obs_addr.size() !== 2) begin
         n_bad++; $display("FAIL ovr_count: got %0d writes expected 2", obs_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
         n_cmp++;
         if (obs_addr[i] !== 32'h5000 + 32'(i) * 4 || obs_data[i] !== words[i]) begin
            n_bad++;
            $display("FAIL ovr_write%0d: got %h/%h expected %h/%h", i, obs_addr[i], obs_data[i],
                     32'h5000 + 32'(i) * 4, words[i]);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int stray;
      run_job(32'h6000, 32'd16, 0, 0, 0, 1000, 2, 100);
      n_cmp++; if (!aborted) begin n_bad++; $display("FAIL rst_mid_reach: 2 writes never seen"); end
      n_cmp++; if (snap !== 7'b0) begin
         n_bad++; $display("FAIL rst_mid_outputs: we/addr/data/busy/done/ready/req=%b expected 0000000", snap); end
      stray = 0;
      repeat (4) begin @(negedge clk); if (we_global || busy || done) stray++; end
      n_cmp++; if (stray !== 0) begin
         n_bad++; $display("FAIL rst_mid_quiet: %0d active cycles after reset expected 0", stray); end
      run_job(32'h6000, 32'd16, 0, 0, 0, 1000, -1, 200);
      n_cmp++; if (timed_out || obs_addr.size() !== 4) begin
         n_bad++; $display("FAIL rst_restart_count: got %0d writes (timeout=%0d) expected 4", obs_addr.size(), timed_out); end
      for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
         n_cmp++;
         if (obs_addr[i] !== 32'h6000 + 32'(i) * 4 || obs_data[i] !== words[i]) begin
            n_bad++;
            $display("FAIL rst_restart_write%0d: got %h/%h expected %h/%h", i, obs_addr[i], obs_data[i],
                     32'h6000 + 32'(i) * 4, words[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] b, s, ea;
      int          total, errs;
      for (int j = 0; j < 7; j++) begin
         b = $urandom; b[1:0] = 2'b00;
         s = 32'($urandom_range(0, 20)) * 4;
         if (j == 0) begin b = 32'hFFFF_FFF8; s = 32'd16; end
         total = int'(s >> 2);
         run_job(b, s, 3, 0, 1, 1000, -1, 600);
         errs = 0;
         for (int i = 0; i < obs_addr.size() && i < total; i++) begin
            ea = b + 32'(i) * 4;
            if (obs_addr[i] !== ea || obs_data[i] !== words[i]) errs++;
         end
         n_cmp++;
         if (timed_out || obs_addr.size() !== total || errs != 0) begin
            n_bad++;
            $display("FAIL rand%0d_writes: base=%h size=%0d got %0d writes (%0d wrong, timeout=%0d) expected %0d",
                     j, b, s, obs_addr.size(), errs, timed_out, total);
         end
         n_cmp++;
         if (done_cnt !== 1 || we_viol !== 0 || (total > 0 && done_with_we !== 1'b1) || ready_extra !== 0) begin
            n_bad++;
            $display("FAIL rand%0d_ctrl: done=%0d we_off=%0d with_last_we=%b extra_ready=%0d expected 1 0 1 0",
                     j, done_cnt, we_viol, done_with_we, ready_extra);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_grant_toggle();
      test_size_zero();
      test_overrun();
      test_reset_mid_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
